// File: rtl/sram_gen2_pkg.sv
// Shared types and constants for the 1RW/1R SRAM wrapper.
package sram_gen2_pkg;

  // Array lifecycle: INIT walks the array writing zeros, READY serves requests.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_t;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_BYTE_WIDTH     = 8;
  localparam int DEF_READ_LATENCY   = 1;
  localparam int DEF_COLLISION_MODE = 0;
  localparam int DEF_CLEAR_ON_RESET = 1;

  // Width of the saturating collision counter.
  localparam int COLL_CNT_WIDTH = 16;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data pipeline: delays a captured read word and its valid by the
// configured latency and holds the last delivered word between reads.
module sram_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);

  logic                  last_req;
  logic [DATA_WIDTH-1:0] last_data;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  mid_valid;
    logic [DATA_WIDTH-1:0] mid_data;

    // Extra stage for two-cycle latency; valid is cleared by reset so an
    // in-flight read never completes across a reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mid_valid <= 1'b0;
        mid_data  <= '0;
      end else begin
        mid_valid <= req;
        if (req) mid_data <= rdata;
      end
    end

    assign last_req  = mid_valid;
    assign last_data = mid_data;
  end else begin : g_lat1
    assign last_req  = req;
    assign last_data = rdata;
  end

  // Output stage: pulse valid once per read, otherwise hold the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      dout_valid <= last_req;
      if (last_req) dout <= last_data;
    end
  end

endmodule

// File: rtl/sram_1rw1r_gen2.sv
// Single-clock SRAM with one read/write port and one read-only port,
// byte-masked writes, optional zero-clear after reset and collision tracking.
module sram_1rw1r_gen2
  import sram_gen2_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int BYTE_WIDTH     = DEF_BYTE_WIDTH,
  parameter int READ_LATENCY   = DEF_READ_LATENCY,
  parameter int COLLISION_MODE = DEF_COLLISION_MODE,
  parameter int CLEAR_ON_RESET = DEF_CLEAR_ON_RESET,
  localparam int NUM_WMASKS    = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      csb0,
  input  logic                      web0,
  input  logic [NUM_WMASKS-1:0]     wmask0,
  input  logic [ADDR_WIDTH-1:0]     addr0,
  input  logic [DATA_WIDTH-1:0]     din0,
  output logic [DATA_WIDTH-1:0]     dout0,
  output logic                      dout0_valid,
  input  logic                      csb1,
  input  logic [ADDR_WIDTH-1:0]     addr1,
  output logic [DATA_WIDTH-1:0]     dout1,
  output logic                      dout1_valid,
  output logic                      init_done,
  output logic                      collision,
  output logic [COLL_CNT_WIDTH-1:0] collision_count
);

  // Request handshake: a port request is accepted on a rising edge only when
  // init_done is high; there is no back-pressure, every accepted read returns
  // exactly READ_LATENCY edges later as a one-cycle valid pulse.

  if ((DATA_WIDTH % BYTE_WIDTH) != 0 || (READ_LATENCY != 1 && READ_LATENCY != 2)) begin : g_param_err
    $error("sram_1rw1r_gen2: illegal DATA_WIDTH/BYTE_WIDTH or READ_LATENCY");
  end

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam sram_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT : READY;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  sram_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;

  logic                  wr_en, rd0_en, rd1_en, col_det, col_into_last;
  logic [DATA_WIDTH-1:0] rd0_data, rd1_data;
  logic [READ_LATENCY-1:0] col_sr;

  assign init_done = (state_q == READY);
  assign wr_en     = init_done & ~csb0 & ~web0;
  assign rd0_en    = init_done & ~csb0 &  web0;
  assign rd1_en    = init_done & ~csb1;
  assign col_det   = wr_en & rd1_en & (addr0 == addr1);

  // State register and clear-address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // Next state: INIT advances one address per cycle and leaves after the top one.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == INIT) begin
      init_addr_d = init_addr_q + 1'b1;
      if (init_addr_q == {ADDR_WIDTH{1'b1}}) state_d = READY;
    end
  end

  // Array write: zero-clear during INIT, otherwise byte-masked port-0 writes.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[init_addr_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NUM_WMASKS; b++) begin
        if (wmask0[b]) mem[addr0][b*BYTE_WIDTH +: BYTE_WIDTH] <= din0[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Read words; in write-through mode port 1 sees the masked new bytes on a collision.
  always_comb begin
    rd0_data = mem[addr0];
    rd1_data = mem[addr1];
    if (COLLISION_MODE == 1 && col_det) begin
      for (int b = 0; b < NUM_WMASKS; b++) begin
        if (wmask0[b]) rd1_data[b*BYTE_WIDTH +: BYTE_WIDTH] = din0[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  sram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe0 (
    .clk(clk), .rst_n(rst_n), .req(rd0_en), .rdata(rd0_data),
    .dout(dout0), .dout_valid(dout0_valid)
  );

  sram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe1 (
    .clk(clk), .rst_n(rst_n), .req(rd1_en), .rdata(rd1_data),
    .dout(dout1), .dout_valid(dout1_valid)
  );

  // The flag entering the last collision stage is the one that pulses next edge.
  always_comb begin
    col_into_last = col_det;
    if (READ_LATENCY == 2) col_into_last = col_sr[0];
  end

  // Collision flag pipeline aligned with port-1 valid, plus saturating counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_sr          <= '0;
      collision_count <= '0;
    end else begin
      col_sr[0] <= col_det;
      for (int i = 1; i < READ_LATENCY; i++) col_sr[i] <= col_sr[i-1];
      if (col_into_last && collision_count != {COLL_CNT_WIDTH{1'b1}})
        collision_count <= collision_count + 1'b1;
    end
  end

  assign collision = col_sr[READ_LATENCY-1];

endmodule

// File: tb/tb_sram_1rw1r_gen2.sv
// Directed bench: two instances share stimulus -- dut_a (old-data mode,
// latency 1) and dut_b (write-through mode, latency 2).
module tb_sram_1rw1r_gen2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0;

  logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1;
  logic        a_v0, a_v1, b_v0, b_v1;
  logic        a_init_done, b_init_done, a_col, b_col;
  logic [15:0] a_count, b_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q_a0[$], exp_q_a1[$], exp_q_b0[$], exp_q_b1[$];
  int n_a0, n_a1, n_b0, n_b1;

  // Clock and DUTs.
  always #5 clk = ~clk;

  sram_1rw1r_gen2 #(.READ_LATENCY(1), .COLLISION_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(a_dout0), .dout0_valid(a_v0),
    .csb1(csb1), .addr1(addr1), .dout1(a_dout1), .dout1_valid(a_v1),
    .init_done(a_init_done), .collision(a_col), .collision_count(a_count)
  );

  sram_1rw1r_gen2 #(.READ_LATENCY(2), .COLLISION_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(b_dout0), .dout0_valid(b_v0),
    .csb1(csb1), .addr1(addr1), .dout1(b_dout1), .dout1_valid(b_v1),
    .init_done(b_init_done), .collision(b_col), .collision_count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 8'h00; din0 = 32'h0;
    csb1 = 1'b1; addr1 = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    tick();
    idle();
  endtask

  task automatic rd0(input string tag, input logic [7:0] a, input logic [31:0] exp);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a;
    tick();
    idle();
    chk({tag, "_a_data"}, a_dout0, exp);
    chk({tag, "_a_valid"}, {31'b0, a_v0}, 32'd1);
    chk({tag, "_b_early"}, {31'b0, b_v0}, 32'd0);
    tick();
    chk({tag, "_a_pulse"}, {31'b0, a_v0}, 32'd0);
    chk({tag, "_a_hold"}, a_dout0, exp);
    chk({tag, "_b_valid"}, {31'b0, b_v0}, 32'd1);
    chk({tag, "_b_data"}, b_dout0, exp);
  endtask

  task automatic rd1(input string tag, input logic [7:0] a, input logic [31:0] exp);
    csb1 = 1'b0; addr1 = a;
    tick();
    idle();
    chk({tag, "_a_data"}, a_dout1, exp);
    chk({tag, "_a_valid"}, {31'b0, a_v1}, 32'd1);
    tick();
    chk({tag, "_b_valid"}, {31'b0, b_v1}, 32'd1);
    chk({tag, "_b_data"}, b_dout1, exp);
  endtask

  // Counts cycles from reset release to init_done; optionally pokes requests mid-INIT.
  task automatic wait_init(input string tag, input bit poke);
    int cnt = 0;
    bit saw_valid = 0;
    while (!a_init_done && cnt < 400) begin
      idle();
      if (poke && cnt == 10) begin
        csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h03; din0 = 32'hA5A5A5A5; wmask0 = 4'hF;
      end
      if (poke && cnt == 20) begin
        csb1 = 1'b0; addr1 = 8'h03; csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h04;
      end
      tick();
      cnt++;
      if (a_v0 || a_v1 || b_v0 || b_v1) saw_valid = 1;
    end
    idle();
    chk({tag, "_cycles"}, cnt, 32'd256);
    chk({tag, "_b_done"}, {31'b0, b_init_done}, 32'd1);
    chk({tag, "_no_valid"}, {31'b0, saw_valid}, 32'd0);
  endtask

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  task automatic scoreboard();
    if (a_v0) begin n_a0++; if (exp_q_a0.size() != 0) chk("sb_a0", a_dout0, exp_q_a0.pop_front()); end
    if (a_v1) begin n_a1++; if (exp_q_a1.size() != 0) chk("sb_a1", a_dout1, exp_q_a1.pop_front()); end
    if (b_v0) begin n_b0++; if (exp_q_b0.size() != 0) chk("sb_b0", b_dout0, exp_q_b0.pop_front()); end
    if (b_v1) begin n_b1++; if (exp_q_b1.size() != 0) chk("sb_b1", b_dout1, exp_q_b1.pop_front()); end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) tick();

    // Reset values.
    chk("rst_a_init_done", {31'b0, a_init_done}, 32'd0);
    chk("rst_b_init_done", {31'b0, b_init_done}, 32'd0);
    chk("rst_a_dout0", a_dout0, 32'h0);
    chk("rst_b_dout1", b_dout1, 32'h0);
    chk("rst_valids", {28'b0, a_v0, a_v1, b_v0, b_v1}, 32'h0);
    chk("rst_collision", {30'b0, a_col, b_col}, 32'h0);
    chk("rst_count", {a_count, b_count}, 32'h0);

    // Clear after reset takes exactly 256 cycles; cleared array reads zero.
    rst_n = 1'b1;
    wait_init("init1", 1'b0);
    rd1("clr_55", 8'h55, 32'h0);
    rd0("clr_ff", 8'hFF, 32'h0);

    // Byte-masked write.
    wr(8'h10, 32'h11223344, 4'hF);
    rd0("full_wr", 8'h10, 32'h11223344);
    wr(8'h10, 32'hDEADBEEF, 4'b0101);
    rd0("mask_wr", 8'h10, 32'h11AD33EF);
    wr(8'h10, 32'hFFFFFFFF, 4'b0000);
    rd1("mask_zero", 8'h10, 32'h11AD33EF);

    // Same-edge write and port-1 read at 0x20 (holds zero).
    csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h20; din0 = 32'hCAFEF00D; wmask0 = 4'hF;
    csb1 = 1'b0; addr1 = 8'h20;
    tick();
    idle();
    chk("col_a_dout1", a_dout1, 32'h00000000);
    chk("col_a_flags", {30'b0, a_v1, a_col}, 32'h3);
    chk("col_a_count", {16'b0, a_count}, 32'd1);
    chk("col_b_early", {30'b0, b_v1, b_col}, 32'h0);
    tick();
    chk("col_a_pulse", {31'b0, a_col}, 32'd0);
    chk("col_b_dout1", b_dout1, 32'hCAFEF00D);
    chk("col_b_flags", {30'b0, b_v1, b_col}, 32'h3);
    chk("col_b_count", {16'b0, b_count}, 32'd1);
    rd1("after_col", 8'h20, 32'hCAFEF00D);

    // Counter saturation; wmask0=0 collisions at 0x10 still count.
    csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h10; din0 = 32'h99999999; wmask0 = 4'h0;
    csb1 = 1'b0; addr1 = 8'h10;
    for (int i = 0; i < 65540; i++) begin
      tick();
      if (i == 99) begin
        chk("sat_a_mid", {16'b0, a_count}, 32'd101);
        chk("sat_b_mid", {16'b0, b_count}, 32'd100);
      end
    end
    idle();
    tick();
    tick();
    chk("sat_a", {16'b0, a_count}, 32'h0000FFFF);
    chk("sat_b", {16'b0, b_count}, 32'h0000FFFF);
    chk("sat_a_dout1", a_dout1, 32'h11AD33EF);
    chk("sat_b_dout1", b_dout1, 32'h11AD33EF);
    chk("sat_col_idle", {30'b0, a_col, b_col}, 32'h0);

    // Streaming reads on both ports, distinct addresses.
    for (int i = 0; i < 128; i++) wr(8'h40 + i[7:0], pat(8'h40 + i[7:0]), 4'hF);
    n_a0 = 0; n_a1 = 0; n_b0 = 0; n_b1 = 0;
    for (int i = 0; i < 64; i++) begin
      csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h40 + i[7:0];
      csb1 = 1'b0; addr1 = 8'h80 + i[7:0];
      exp_q_a0.push_back(pat(addr0)); exp_q_b0.push_back(pat(addr0));
      exp_q_a1.push_back(pat(addr1)); exp_q_b1.push_back(pat(addr1));
      tick();
      scoreboard();
    end
    idle();
    repeat (4) begin
      tick();
      scoreboard();
    end
    chk("stream_counts_a", {n_a0[15:0], n_a1[15:0]}, {16'd64, 16'd64});
    chk("stream_counts_b", {n_b0[15:0], n_b1[15:0]}, {16'd64, 16'd64});
    chk("stream_q_left", exp_q_a0.size() + exp_q_a1.size() + exp_q_b0.size() + exp_q_b1.size(), 32'd0);
    chk("stream_hold_a0", a_dout0, pat(8'h7F));
    chk("stream_hold_b1", b_dout1, pat(8'hBF));

    // Reset during an in-flight read (dut_b has it mid-pipeline).
    csb1 = 1'b0; addr1 = 8'h10;
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_b_v1", {31'b0, b_v1}, 32'd0);
    chk("rst_mid_b_dout1", b_dout1, 32'h0);
    chk("rst_mid_a_count", {16'b0, a_count}, 32'd0);
    tick();
    chk("rst_mid_b_late", {31'b0, b_v1}, 32'd0);

    // Reset again at INIT address 100; clear restarts from 0.
    rst_n = 1'b1;
    repeat (100) tick();
    chk("init100_busy", {31'b0, a_init_done}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_init("init2", 1'b1);
    rd0("lost_wr", 8'h03, 32'h0);
    rd1("reclear", 8'h10, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
